// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and helpers for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpMul  = 4'd2;
    localparam logic [3:0] OpDiv  = 4'd3;
    localparam logic [3:0] OpShlA = 4'd4;
    localparam logic [3:0] OpShrA = 4'd5;
    localparam logic [3:0] OpSqrA = 4'd6;
    localparam logic [3:0] OpSqrB = 4'd7;
    localparam logic [3:0] OpShlB = 4'd8;
    localparam logic [3:0] OpShrB = 4'd9;

    // Mode select for the iterative multiply/divide unit.
    localparam logic MdMul = 1'b0;
    localparam logic MdDiv = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    // Ops that use the iterative unit; DIV by zero is short-circuited by the caller.
    function automatic logic is_multicycle(input logic [3:0] op);
        case (op)
            OpMul, OpDiv, OpSqrA, OpSqrB: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle, sharing
// a single 2*WIDTH accumulator. hi/lo present the accumulator after the pending step.
module seq_muldiv_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             fin,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q, acc_step;
    logic [WIDTH-1:0]   opnd_q;
    logic               mode_q;
    logic               active_q;
    logic [CntW-1:0]    cnt_q;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;

    always_comb begin
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        diff  = trial - {1'b0, opnd_q};
        if (mode_q == MdDiv) begin
            // Restore by keeping the shifted remainder when the trial goes negative.
            if (!diff[WIDTH]) begin
                acc_step = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = {sum, acc_q[WIDTH-1:1]};
        end
    end

    assign fin = active_q && (cnt_q == CntW'(WIDTH - 1));
    assign hi  = acc_step[2*WIDTH-1:WIDTH];
    assign lo  = acc_step[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            mode_q   <= MdMul;
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else if (go) begin
            // Low half holds the multiplier or the dividend; opnd holds the other operand.
            acc_q    <= {{WIDTH{1'b0}}, (mode == MdDiv) ? a : b};
            opnd_q   <= (mode == MdDiv) ? b : a;
            mode_q   <= mode;
            active_q <= 1'b1;
            cnt_q    <= '0;
        end else if (active_q) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + CntW'(1);
            if (fin) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: FSM with start/busy/done handshake, single-cycle datapath,
// status flags and registered outputs; MUL/DIV/SQR go through seq_muldiv_unit.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             zero,
    output logic             div_zero,
    output logic             illegal_op
);

    state_e state_q, state_d;

    logic             accept, take, multi, go, fin;
    logic             unit_mode;
    logic [WIDTH-1:0] unit_a, unit_b, unit_hi, unit_lo;
    logic             is_div_q;

    logic [WIDTH-1:0] sc_res, sc_hi;
    logic             sc_carry, sc_dz, sc_ill;

    logic             cap;
    logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d;
    logic             carry_q, carry_d, zero_q, zero_d, dz_q, dz_d, ill_q, ill_d;

    assign accept = (state_q != StCalc);
    assign take   = start && accept;
    assign multi  = is_multicycle(op) && !((op == OpDiv) && (b == '0));
    assign go     = take && multi;

    assign unit_mode = (op == OpDiv) ? MdDiv : MdMul;
    assign unit_a    = (op == OpSqrB) ? b : a;
    assign unit_b    = (op == OpSqrA) ? a : b;

    seq_muldiv_unit #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk  (clk),
        .rst_n(rst_n),
        .go   (go),
        .mode (unit_mode),
        .a    (unit_a),
        .b    (unit_b),
        .fin  (fin),
        .hi   (unit_hi),
        .lo   (unit_lo)
    );

    always_comb begin
        sc_res   = '0;
        sc_hi    = '0;
        sc_carry = 1'b0;
        sc_dz    = 1'b0;
        sc_ill   = 1'b0;
        case (op)
            OpAdd:  {sc_carry, sc_res} = {1'b0, a} + {1'b0, b};
            OpSub: begin
                sc_res   = a - b;
                sc_carry = (a < b);
            end
            OpShlA: {sc_carry, sc_res} = {a, 1'b0};
            OpShlB: {sc_carry, sc_res} = {b, 1'b0};
            OpShrA: {sc_res, sc_carry} = {1'b0, a};
            OpShrB: {sc_res, sc_carry} = {1'b0, b};
            OpDiv: begin
                // Only reaches the output path when b == 0.
                sc_dz  = 1'b1;
                sc_res = '1;
                sc_hi  = a;
            end
            OpMul, OpSqrA, OpSqrB: ;
            default: sc_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StCalc:  state_d = fin ? StDone : StCalc;
            default: begin
                if (take) begin
                    state_d = multi ? StCalc : StDone;
                end else begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_comb begin
        cap     = 1'b0;
        res_d   = res_q;
        hi_d    = hi_q;
        carry_d = carry_q;
        dz_d    = dz_q;
        ill_d   = ill_q;
        if (take && !multi) begin
            cap     = 1'b1;
            res_d   = sc_res;
            hi_d    = sc_hi;
            carry_d = sc_carry;
            dz_d    = sc_dz;
            ill_d   = sc_ill;
        end else if ((state_q == StCalc) && fin) begin
            cap     = 1'b1;
            res_d   = unit_lo;
            hi_d    = unit_hi;
            carry_d = is_div_q ? 1'b0 : |unit_hi;
            dz_d    = 1'b0;
            ill_d   = 1'b0;
        end
        zero_d = cap ? ({hi_d, res_d} == '0) : zero_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            is_div_q <= 1'b0;
            res_q    <= '0;
            hi_q     <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            dz_q     <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (go) begin
                is_div_q <= (op == OpDiv);
            end
            res_q   <= res_d;
            hi_q    <= hi_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            dz_q    <= dz_d;
            ill_q   <= ill_d;
        end
    end

    assign busy       = (state_q == StCalc);
    assign done       = (state_q == StDone);
    assign result     = res_q;
    assign result_hi  = hi_q;
    assign carry      = carry_q;
    assign zero       = zero_q;
    assign div_zero   = dz_q;
    assign illegal_op = ill_q;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the 8-bit combinational ALU; keeps the same 4-bit opcode map.
- Adds registered outputs, a start/busy/done handshake and status flags.
- Multiply and divide are iterative, one bit per cycle; all other ops complete in one cycle.
- Sits between the register file and the datapath controller, which issues one operation at a time and writes back on done.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; operands and op sampled on the clk edge where start=1 and the block is accepting.
- op  in  4  opcode (alu_pkg encodings).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- busy  out  1  high while an accepted op is in progress.
- done  out  1  one-cycle pulse; result and flags valid from this cycle.
- result  out  WIDTH  low word / quotient.
- result_hi  out  WIDTH  product high word / remainder; 0 for other ops.
- carry  out  1  carry/borrow/shifted-out bit / product overflow.
- zero  out  1  full result (result_hi:result) == 0.
- div_zero  out  1  last op was DIV with b==0.
- illegal_op  out  1  last op code was unused.

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output 0; internal operand/accumulator regs 0. Reset mid-operation aborts the op and produces no done pulse.
- FSM states IDLE, CALC, DONE.
- Accepting means state IDLE or DONE, so back-to-back issue is allowed. start during CALC is ignored and not queued.
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHL A, 5 SHR A, 6 SQR A, 7 SQR B, 8 SHL B, 9 SHR B, 10-15 illegal.
- Single-cycle ops (ADD, SUB, shifts, illegal, DIV with b==0):
  - accept -> DONE. done=1 on the cycle after the accept edge (latency 1); busy stays 0.
- MUL, SQR A, SQR B:
  - accept -> CALC for WIDTH cycles (shift-add, one multiplier bit per cycle) -> DONE.
  - busy=1 throughout CALC; done WIDTH+1 cycles after accept.
- DIV with b!=0: restoring division, WIDTH cycles in CALC, same timing as MUL.
- DONE lasts exactly one cycle (done=1, busy=0), then IDLE unless a new start is accepted.
- Outputs are registered and updated only on the cycle done rises; they hold until the next done.
- ADD: {carry,result} = a+b, full WIDTH+1-bit sum.
- SUB: result = a-b mod 2^WIDTH; carry = borrow (a<b).
- SHL: result = x<<1; carry = x[WIDTH-1].
- SHR: result = x>>1 (logical); carry = x[0].
- MUL / SQR: {result_hi,result} = 2*WIDTH-bit product; carry = |result_hi.
- DIV: result = a/b, result_hi = a%b, carry = 0.
- DIV with b==0: div_zero=1, result = all ones, result_hi = a, carry = 0.
- Illegal op: illegal_op=1; result, result_hi and carry = 0; zero = 1.
- div_zero and illegal_op are cleared by the next done.

Decomposition:
- alu_pkg holds the opcode localparams and the FSM state encoding (IDLE/CALC/DONE), plus the function is_multicycle(op).
- One sub-module: seq_muldiv_unit(WIDTH). Iterative shift-add multiplier and restoring divider sharing one 2*WIDTH accumulator and a bit counter. Interface: go, mode, a, b -> fin, hi, lo.
- The top level holds the FSM, single-cycle datapath, flags and output registers.

Test Plan:
- ADD a=200, b=100 -> one cycle later: done=1, result=44, carry=1, zero=0, busy never high.
- SUB a=5, b=7 -> result=254, carry=1. SHL A a=0x81 -> result=0x02, carry=1.
- MUL a=255, b=255 -> busy high 8 cycles, done 9 cycles after accept: result_hi=0xFE, result=0x01, carry=1. start pulsed mid-CALC is ignored and no extra done appears.
- DIV a=200, b=7 -> done after 9 cycles: result=28, result_hi=4. DIV a=200, b=0 -> latency 1: div_zero=1, result=0xFF, result_hi=200.
- op=4'b1010 -> illegal_op=1, result=0, zero=1. A following ADD 0+0 -> illegal_op=0, zero=1.
- rst_n low at cycle 3 of a MUL -> all outputs 0 immediately, no done. New ADD 1+1 after release -> result=2 at latency 1.
